// File: rtl/ram32_byte_host_pkg.sv
// Shared types, widths and byte helpers for the RAM32 byte-stream host.
package ram32_byte_host_pkg;

    localparam int unsigned RAM_ADDR_W   = 5;
    localparam int unsigned RAM_DATA_W   = 32;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned BYTES        = 4;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned MASK_W       = 4;
    localparam int unsigned CMD_WR_BIT   = 7;
    localparam int unsigned CMD_ADDR_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MASK,
        ST_DATA,
        ST_WR_ISSUE,
        ST_RD_ISSUE,
        ST_RD_CAP,
        ST_SEND
    } state_e;

    // One registered RAM port cycle.
    typedef struct packed {
        logic                  en;
        logic [MASK_W-1:0]     we;
        logic [RAM_ADDR_W-1:0] a;
        logic [RAM_DATA_W-1:0] di;
    } ram_req_t;

    function automatic logic [BYTE_W-1:0] get_byte(input logic [RAM_DATA_W-1:0] w,
                                                   input logic [IDX_W-1:0]      idx);
        return w[{idx, 3'b000} +: BYTE_W];
    endfunction

    function automatic logic [RAM_DATA_W-1:0] set_byte(input logic [RAM_DATA_W-1:0] w,
                                                       input logic [IDX_W-1:0]      idx,
                                                       input logic [BYTE_W-1:0]     b);
        logic [RAM_DATA_W-1:0] r;
        r = w;
        r[{idx, 3'b000} +: BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/ram32_word_pack.sv
// 32-bit word buffer loadable either one byte lane at a time or as a whole word.
module ram32_word_pack
    import ram32_byte_host_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  byte_we,
    input  logic [IDX_W-1:0]      byte_idx,
    input  logic [BYTE_W-1:0]     byte_in,
    input  logic                  word_we,
    input  logic [RAM_DATA_W-1:0] word_in,
    output logic [RAM_DATA_W-1:0] word_q
);

    logic [RAM_DATA_W-1:0] word_d;

    // Whole-word load wins over a lane load.
    always_comb begin
        word_d = word_q;
        if (word_we) begin
            word_d = word_in;
        end else if (byte_we) begin
            word_d = set_byte(word_q, byte_idx, byte_in);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/ram32_byte_host.sv
// Byte-stream command host for the 32x32 byte-writable RAM macro.
// Write frame: cmd, mask, 4 data bytes LSB first. Read frame: cmd, reply 4 bytes LSB first.
module ram32_byte_host
    import ram32_byte_host_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [MASK_W-1:0]     mask_q, mask_d;
    logic [RAM_ADDR_W-1:0] addr_q, addr_d;
    ram_req_t              ram_q, ram_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic [BYTE_W-1:0]     out_data_q, out_data_d;

    logic                  pack_we;
    logic                  reply_we;
    logic [RAM_DATA_W-1:0] pack_word;
    logic [RAM_DATA_W-1:0] reply_word;
    logic                  in_fire;

    assign in_fire = in_valid & in_ready_q;

    ram32_word_pack u_pack (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .byte_we  (pack_we),
        .byte_idx (cnt_q),
        .byte_in  (in_data),
        .word_we  (1'b0),
        .word_in  ('0),
        .word_q   (pack_word)
    );

    ram32_word_pack u_reply (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .byte_we  (1'b0),
        .byte_idx ('0),
        .byte_in  ('0),
        .word_we  (reply_we),
        .word_in  (RAM_DATA_W'(ram_do)),
        .word_q   (reply_word)
    );

    // Next-state and registered-output decode; RAM strobes are one-cycle pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        ram_d       = ram_q;
        ram_d.en    = 1'b0;
        ram_d.we    = '0;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        pack_we     = 1'b0;
        reply_we    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    addr_d = in_data[CMD_ADDR_LSB +: RAM_ADDR_W];
                    if (in_data[CMD_WR_BIT]) begin
                        state_d = ST_MASK;
                    end else begin
                        state_d  = ST_RD_ISSUE;
                        ram_d.en = 1'b1;
                        ram_d.a  = in_data[CMD_ADDR_LSB +: RAM_ADDR_W];
                    end
                end
            end
            ST_MASK: begin
                if (in_fire) begin
                    mask_d  = in_data[MASK_W-1:0];
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (in_fire) begin
                    pack_we = 1'b1;
                    cnt_d   = cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(BYTES - 1)) begin
                        state_d  = ST_WR_ISSUE;
                        ram_d.en = 1'b1;
                        ram_d.we = mask_q;
                        ram_d.a  = addr_q;
                        ram_d.di = set_byte(pack_word, cnt_q, in_data);
                    end
                end
            end
            ST_WR_ISSUE: begin
                state_d = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                reply_we = 1'b1;
                cnt_d    = '0;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                // First SEND cycle primes the output register from the reply buffer.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = get_byte(reply_word, cnt_q);
                end else if (out_ready) begin
                    cnt_d = cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(BYTES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = get_byte(reply_word, cnt_q + IDX_W'(1));
                    end
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_MASK) || (state_d == ST_DATA);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mask_q      <= '0;
            addr_q      <= '0;
            ram_q       <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            ram_q       <= ram_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ram_en    = ram_q.en;
    assign ram_we    = ram_q.we;
    assign ram_a     = ADDR_W'(ram_q.a);
    assign ram_di    = DATA_W'(ram_q.di);

endmodule

// File: tb/tb_ram32_byte_host.sv
// Randomised bench for ram32_byte_host with a behavioural RAM macro and a word-level reference model.
module tb_ram32_byte_host;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [4:0]  ram_a;
    logic [31:0] ram_di;
    logic [31:0] ram_do;

    always #5 CLK = ~CLK;

    ram32_byte_host dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_a     (ram_a),
        .ram_di    (ram_di),
        .ram_do    (ram_do)
    );

    // RAM macro: registered read, zero output when not enabled, per-lane write.
    logic [31:0] mem [32];
    logic        clr_mem;
    always @(posedge CLK) begin
        if (clr_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            ram_do <= '0;
        end else if (ram_en) begin
            ram_do <= mem[ram_a];
            for (int l = 0; l < 4; l++)
                if (ram_we[l]) mem[ram_a][8*l +: 8] <= ram_di[8*l +: 8];
        end else begin
            ram_do <= '0;
        end
    end

    typedef struct {
        logic [3:0]  we;
        logic [4:0]  a;
        logic [31:0] di;
        bit          chk_di;
    } issue_t;

    logic [31:0] ref_mem [32];
    issue_t      exp_iss[$];
    logic [7:0]  exp_out[$];
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: RAM strobes against expected issues, reply bytes against expected stream.
    always @(negedge CLK) begin : cmp
        issue_t e;
        if (RST_N && mon_en) begin
            if (ram_en) begin
                if (exp_iss.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ram_en: got 1 expected 0 at %0t", $time);
                end else begin
                    e = exp_iss.pop_front();
                    chk("ram_we", 32'(ram_we), 32'(e.we));
                    chk("ram_a", 32'(ram_a), 32'(e.a));
                    if (e.chk_di) chk("ram_di", ram_di, e.di);
                end
            end else if (ram_we != 4'h0) begin
                chk("ram_we_without_en", 32'(ram_we), 32'h0);
            end
            if (out_valid) begin
                if (exp_out.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_out[0]));
                    if (out_ready) void'(exp_out.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int k;
        int g;
        k = $urandom_range(0, maxgap);
        for (int i = 0; i < k; i++) begin
            @(negedge CLK);
            in_valid = 1'b0;
        end
        @(negedge CLK);
        in_valid = 1'b1;
        in_data  = b;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 100) chk("in_ready_timeout", 32'(in_ready), 32'h1);
        @(posedge CLK);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || !in_ready) && g < 100) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 100) chk("idle_timeout", 32'(busy), 32'h0);
        chk("issues_drained", 32'(exp_iss.size()), 32'h0);
    endtask

    task automatic write_frame(input logic [4:0] a, input logic [3:0] m, input logic [31:0] w,
                               input int gap, input logic [3:0] junk);
        issue_t e;
        e.we = m; e.a = a; e.di = w; e.chk_di = 1'b1;
        exp_iss.push_back(e);
        for (int l = 0; l < 4; l++)
            if (m[l]) ref_mem[a][8*l +: 8] = w[8*l +: 8];
        send_byte({1'b1, junk[1:0], a}, gap);
        send_byte({junk, m}, gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
        wait_idle();
    endtask

    task automatic read_frame(input logic [4:0] a, input int stall, input bit rnd_ready,
                              output logic [31:0] got);
        issue_t e;
        logic [31:0] w;
        int n;
        int g;
        got = '0;
        w = ref_mem[a];
        e.we = 4'h0; e.a = a; e.di = '0; e.chk_di = 1'b0;
        exp_iss.push_back(e);
        for (int i = 0; i < 4; i++) exp_out.push_back(w[8*i +: 8]);
        out_ready = 1'b0;
        send_byte({1'b0, 2'($urandom), a}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rd_latency_low", 32'(out_valid), 32'h0);
        end
        @(negedge CLK);
        chk("rd_latency_high", 32'(out_valid), 32'h1);
        for (int s = 0; s < stall; s++) begin
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_data", 32'(out_data), 32'(w[7:0]));
            chk("stall_busy", 32'(busy), 32'h1);
            @(negedge CLK);
        end
        n = 0;
        g = 0;
        while (n < 4 && g < 200) begin
            @(posedge CLK);
            #1 out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge CLK);
            if (out_valid && out_ready) begin
                got[8*n +: 8] = out_data;
                n++;
            end
            g++;
        end
        if (n < 4) chk("reply_byte_count", 32'(n), 32'h4);
        @(posedge CLK);
        #1 out_ready = 1'b0;
        wait_idle();
        chk("reply_drained", 32'(exp_out.size()), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] got2;
        logic [31:0] expw;
        logic [4:0]  ra;

        RST_N     = 1'b0;
        clr_mem   = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;

        repeat (3) @(negedge CLK);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_ram_en", 32'(ram_en), 32'h0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        chk("rst_ram_a", 32'(ram_a), 32'h0);
        chk("rst_ram_di", ram_di, 32'h0);
        clr_mem = 1'b0;
        RST_N   = 1'b1;
        repeat (2) @(negedge CLK);
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        chk("post_rst_busy", 32'(busy), 32'h0);
        mon_en = 1'b1;

        // Full word write then read back.
        write_frame(5'd5, 4'hF, 32'h12345678, 0, 4'h0);
        read_frame(5'd5, 0, 1'b0, got);
        chk("read5_full", got, 32'h12345678);

        // Lane-1-only write.
        write_frame(5'd5, 4'h2, 32'hDDCCBBAA, 0, 4'h0);
        read_frame(5'd5, 0, 1'b0, got);
        chk("read5_partial", got, 32'h1234BB78);

        // Output back-pressure for 10 cycles.
        read_frame(5'd5, 10, 1'b0, got);
        chk("read5_backpressure", got, 32'h1234BB78);

        // Gapless versus stalled input give the same memory contents.
        write_frame(5'd10, 4'hF, 32'hCAFEF00D, 0, 4'h0);
        write_frame(5'd11, 4'hF, 32'hCAFEF00D, 5, 4'h0);
        read_frame(5'd10, 0, 1'b0, got);
        read_frame(5'd11, 0, 1'b1, got2);
        chk("stall_vs_gapless", got2, got);
        chk("stall_word", got2, 32'hCAFEF00D);

        // Top address, zero mask, and word 0 independence.
        write_frame(5'd31, 4'hF, 32'hA5A55A5A, 0, 4'h0);
        write_frame(5'd31, 4'h0, 32'h11111111, 0, 4'h0);
        read_frame(5'd31, 0, 1'b0, got);
        chk("mask0_keeps_word31", got, 32'hA5A55A5A);
        write_frame(5'd0, 4'hF, 32'h01020304, 0, 4'hF);
        read_frame(5'd0, 0, 1'b0, got);
        chk("word0", got, 32'h01020304);
        read_frame(5'd31, 0, 1'b0, got);
        chk("word31_after_word0", got, 32'hA5A55A5A);

        // Reset in the middle of a write frame to address 3.
        write_frame(5'd3, 4'hF, 32'h33334444, 0, 4'h0);
        send_byte(8'h83, 0);
        send_byte(8'h0F, 0);
        send_byte(8'h99, 0);
        send_byte(8'h88, 0);
        @(negedge CLK);
        RST_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("abort_ram_en", 32'(ram_en), 32'h0);
            chk("abort_in_ready", 32'(in_ready), 32'h0);
            chk("abort_busy", 32'(busy), 32'h0);
            @(negedge CLK);
        end
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("abort_recover_in_ready", 32'(in_ready), 32'h1);
        read_frame(5'd3, 0, 1'b0, got);
        chk("abort_old_value", got, 32'h33334444);

        // Random mix of writes and reads against the reference memory.
        for (int it = 0; it < 40; it++) begin
            ra = 5'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                write_frame(ra, 4'($urandom), $urandom, 3, 4'($urandom));
            end else begin
                expw = ref_mem[ra];
                read_frame(ra, $urandom_range(0, 3), 1'b1, got);
                chk("rand_read", got, expw);
            end
        end

        chk("final_iss_empty", 32'(exp_iss.size()), 32'h0);
        chk("final_out_empty", 32'(exp_out.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
